// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle: tick and serial line in, byte, done pulse and error flags out.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversampled_if #(
    parameter int DBIT = 8
);
    logic            s_tick;
    logic            rx;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_err;
`endif

    modport master (
        input  s_tick,
        input  rx,
        output dout,
        output rx_done_tick,
`ifdef UART_RX_PARITY_EN
        output parity_err,
`endif
        output frame_err
    );

    modport slave (
        output s_tick,
        output rx,
        input  dout,
        input  rx_done_tick,
`ifdef UART_RX_PARITY_EN
        input  parity_err,
`endif
        input  frame_err
    );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver: start detect, mid-bit data sampling, stop check.
// Optional even-parity bit when UART_RX_PARITY_EN is defined.
module uart_rx_oversampled #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    uart_rx_oversampled_if.master  bus
);
    localparam int SW = (SB_TICK > 16) ? 5 : 4;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] START  = 3'd1;
    localparam logic [2:0] DATA   = 3'd2;
    localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] PARITY = 3'd4;
`endif

    localparam logic [SW-1:0] S_MID  = SW'(7);
    localparam logic [SW-1:0] S_LAST = SW'(15);
    localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
    localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [2:0]      n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            done_q, done_d;
    logic            fe_q, fe_d;
    logic [1:0]      sync_q, sync_d;
    logic            rx_s;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    assign rx_s = sync_q[1];

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
        dout_d  = dout_q;
        done_d  = 1'b0;
        fe_d    = fe_q;
        sync_d  = {sync_q[0], bus.rx};
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE: begin
                // start detection is not gated by the tick
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (bus.s_tick) begin
                    if (s_q == S_MID) begin
                        s_d = '0;
                        n_d = '0;
                        state_d = rx_s ? IDLE : DATA;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bus.s_tick) begin
                    if (s_q == S_LAST) begin
                        s_d     = '0;
                        par_d   = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
`endif
            STOP: begin
                if (bus.s_tick) begin
                    if (s_q == S_STOP) begin
                        dout_d  = b_q;
                        fe_d    = ~rx_s;
                        done_d  = 1'b1;
                        state_d = IDLE;
`ifdef UART_RX_PARITY_EN
                        perr_d  = ^{b_q, par_q};
`endif
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            dout_q  <= '0;
            done_q  <= 1'b0;
            fe_q    <= 1'b0;
            sync_q  <= 2'b11;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
            fe_q    <= fe_d;
            sync_q  <= sync_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rx_done_tick = done_q;
    assign bus.frame_err    = fe_q;
`ifdef UART_RX_PARITY_EN
    assign bus.parity_err   = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: tick every 4 clk, 64 clk per bit.
// Parity scenario runs only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_oversampled;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_rx_oversampled_if #(.DBIT(8)) bus();

    uart_rx_oversampled #(.DBIT(8), .SB_TICK(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int lat_err = 0;
    int tick_cnt = 0;
    logic [7:0] dq[$];
    logic       fq[$];
`ifdef UART_RX_PARITY_EN
    logic       pq[$];
`endif

    // tick generator plus done monitor; s_tick here is the value seen at the last posedge
    always @(negedge clk) begin
        if (bus.rx_done_tick === 1'b1) begin
            done_cnt <= done_cnt + 1;
            if (bus.s_tick !== 1'b1) lat_err <= lat_err + 1;
            dq.push_back(bus.dout);
            fq.push_back(bus.frame_err);
`ifdef UART_RX_PARITY_EN
            pq.push_back(bus.parity_err);
`endif
        end
        tick_cnt <= (tick_cnt + 1) % 4;
        bus.s_tick <= (tick_cnt == 3);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic v, input int len);
        bus.rx = v;
        wait_clk(len);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v,
                              input int stop_len, input logic has_par,
                              input logic par_v);
        send_bit(1'b0, 64);
        for (int i = 0; i < 8; i++) send_bit(d[i], 64);
        if (has_par) send_bit(par_v, 64);
        send_bit(stop_v, stop_len);
        bus.rx = 1'b1;
    endtask

    function automatic logic [7:0] byte_at(input int idx);
        return (dq.size() > idx) ? dq[idx] : 8'hEE;
    endfunction

    function automatic logic fe_at(input int idx);
        return (fq.size() > idx) ? fq[idx] : 1'bx;
    endfunction

    task automatic test_reset;
        bus.rx = 1'b1;
        reset = 1'b1;
        wait_clk(3);
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL reset_dout got %h exp 00", bus.dout);
        end
        checks++;
        if (bus.rx_done_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b exp 0", bus.rx_done_tick);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_fe got %b exp 0", bus.frame_err);
        end
        reset = 1'b0;
        wait_clk(20);
    endtask

    task automatic test_frame_a5;
        int n0;
        n0 = done_cnt;
        send_frame(8'hA5, 1'b1, 64, 1'b0, 1'b0);
        wait_clk(32);
        checks++;
        if (done_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL a5_done_count got %0d exp 1", done_cnt - n0);
        end
        checks++;
        if (byte_at(n0) !== 8'hA5) begin
            errors++;
            $display("FAIL a5_dout got %h exp a5", byte_at(n0));
        end
        checks++;
        if (fe_at(n0) !== 1'b0) begin
            errors++;
            $display("FAIL a5_frame_err got %b exp 0", fe_at(n0));
        end
        checks++;
        if (lat_err !== 0) begin
            errors++;
            $display("FAIL a5_latency late_pulses %0d exp 0", lat_err);
        end
    endtask

    task automatic test_false_start;
        int n0;
        n0 = done_cnt;
        bus.rx = 1'b0;
        wait_clk(20);
        bus.rx = 1'b1;
        wait_clk(200);
        checks++;
        if (done_cnt - n0 !== 0) begin
            errors++;
            $display("FAIL false_start_done got %0d exp 0", done_cnt - n0);
        end
        checks++;
        if (bus.dout !== 8'hA5) begin
            errors++;
            $display("FAIL false_start_dout got %h exp a5", bus.dout);
        end
    endtask

    task automatic test_frame_err;
        int n0;
        n0 = done_cnt;
        send_frame(8'h3C, 1'b0, 44, 1'b0, 1'b0);
        wait_clk(150);
        checks++;
        if (done_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL ferr_done_count got %0d exp 1", done_cnt - n0);
        end
        checks++;
        if (byte_at(n0) !== 8'h3C) begin
            errors++;
            $display("FAIL ferr_dout got %h exp 3c", byte_at(n0));
        end
        checks++;
        if (fe_at(n0) !== 1'b1) begin
            errors++;
            $display("FAIL ferr_frame_err got %b exp 1", fe_at(n0));
        end
        checks++;
        if (bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_held got %b exp 1", bus.frame_err);
        end
    endtask

    task automatic test_back_to_back;
        int n0;
        n0 = done_cnt;
        send_frame(8'h00, 1'b1, 64, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 64, 1'b0, 1'b0);
        wait_clk(32);
        checks++;
        if (done_cnt - n0 !== 2) begin
            errors++;
            $display("FAIL b2b_done_count got %0d exp 2", done_cnt - n0);
        end
        checks++;
        if (byte_at(n0) !== 8'h00) begin
            errors++;
            $display("FAIL b2b_first got %h exp 00", byte_at(n0));
        end
        checks++;
        if (byte_at(n0 + 1) !== 8'hFF) begin
            errors++;
            $display("FAIL b2b_second got %h exp ff", byte_at(n0 + 1));
        end
        checks++;
        if (fe_at(n0) !== 1'b0 || fe_at(n0 + 1) !== 1'b0) begin
            errors++;
            $display("FAIL b2b_frame_err got %b%b exp 00",
                     fe_at(n0), fe_at(n0 + 1));
        end
        checks++;
        if (lat_err !== 0) begin
            errors++;
            $display("FAIL b2b_latency late_pulses %0d exp 0", lat_err);
        end
    endtask

    task automatic test_reset_midframe;
        int n0;
        logic [7:0] d;
        d = 8'h55;
        n0 = done_cnt;
        send_bit(1'b0, 64);
        for (int i = 0; i < 4; i++) send_bit(d[i], 64);
        bus.rx = d[4];
        wait_clk(20);
        reset = 1'b1;
        wait_clk(2);
        checks++;
        if (bus.dout !== 8'h00) begin
            errors++;
            $display("FAIL midreset_dout got %h exp 00", bus.dout);
        end
        reset = 1'b0;
        bus.rx = 1'b1;
        wait_clk(128);
        checks++;
        if (done_cnt - n0 !== 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d exp 0", done_cnt - n0);
        end
        send_frame(8'h81, 1'b1, 64, 1'b0, 1'b0);
        wait_clk(32);
        checks++;
        if (done_cnt - n0 !== 1) begin
            errors++;
            $display("FAIL midreset_81_count got %0d exp 1", done_cnt - n0);
        end
        checks++;
        if (byte_at(n0) !== 8'h81) begin
            errors++;
            $display("FAIL midreset_81_dout got %h exp 81", byte_at(n0));
        end
        checks++;
        if (bus.dout !== 8'h81 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midreset_81_held got %h/%b exp 81/0",
                     bus.dout, bus.frame_err);
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int n0;
        n0 = done_cnt;
        send_frame(8'h07, 1'b1, 64, 1'b1, 1'b1);
        wait_clk(32);
        send_frame(8'h07, 1'b1, 64, 1'b1, 1'b0);
        wait_clk(32);
        checks++;
        if (done_cnt - n0 !== 2) begin
            errors++;
            $display("FAIL par_done_count got %0d exp 2", done_cnt - n0);
        end
        checks++;
        if (byte_at(n0) !== 8'h07 || byte_at(n0 + 1) !== 8'h07) begin
            errors++;
            $display("FAIL par_dout got %h %h exp 07 07",
                     byte_at(n0), byte_at(n0 + 1));
        end
        checks++;
        if (pq.size() < n0 + 2 || pq[n0] !== 1'b0 || pq[n0 + 1] !== 1'b1) begin
            errors++;
            $display("FAIL par_err got size %0d exp 0 then 1", pq.size());
        end
    endtask
`endif

    initial begin
        bus.rx = 1'b1;
        test_reset();
        test_frame_a5();
        test_false_start();
        test_frame_err();
        test_back_to_back();
        test_reset_midframe();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
